// File: rtl/text_cmd_responder.sv
// Command-bus register responder for the text cell RAM: cursor/staged-cell registers,
// single-cell commits, and whole-screen fills through the cell write port.
module text_cmd_responder #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int AW   = 13
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_cmd_clk,
  input  logic          i_we,
  input  logic [6:0]    i_addr,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_busy,
  output logic          o_cell_we,
  output logic [AW-1:0] o_cell_addr,
  output logic [23:0]   o_cell_data
);

  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [7:0]    COL_MAX   = 8'(COLS - 1);
  localparam logic [7:0]    ROW_MAX   = 8'(ROWS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_next;
  logic [AW-1:0] fill_cnt, fill_cnt_next;
  logic          cmd_hist;
  logic [7:0]    col, row, chr, fg, bg, ctrl;
  logic          commit_q;
  logic [AW-1:0] commit_addr;
  logic [23:0]   cell_data_q;
  logic [7:0]    rd_data;
  logic          cmd_edge, wr_ok, wr_commit, wr_fill, fill_done;
  logic [AW-1:0] cursor_addr;

  // Writes are only accepted on a fresh strobe edge while no fill is running.
  assign cmd_edge    = i_cmd_clk & ~cmd_hist;
  assign wr_ok       = cmd_edge & i_we & (state == IDLE);
  assign wr_commit   = wr_ok & (i_addr == 7'h4A);
  assign wr_fill     = wr_ok & (i_addr == 7'h4B);
  assign fill_done   = (state == FILL) && (fill_cnt == LAST_CELL);
  assign cursor_addr = AW'(row) * AW'(COLS) + AW'(col);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    o_busy        = 1'b0;
    case (state)
      IDLE: begin
        if (wr_fill) begin
          state_next    = FILL;
          fill_cnt_next = '0;
        end
      end
      FILL: begin
        o_busy        = 1'b1;
        fill_cnt_next = fill_cnt + AW'(1);
        if (fill_done) begin
          state_next    = IDLE;
          fill_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    o_cell_we   = commit_q | o_busy;
    o_cell_addr = o_busy ? fill_cnt : commit_addr;
    o_cell_data = cell_data_q;
  end

  always_comb begin
    rd_data = 8'h00;
    case (i_addr)
      7'h40: rd_data = col;
      7'h41: rd_data = row;
      7'h46: rd_data = chr;
      7'h48: rd_data = fg;
      7'h49: rd_data = bg;
      7'h4A: rd_data = {7'b0, o_busy};
      7'h4B: rd_data = {7'b0, o_busy};
      7'h4C: rd_data = ctrl;
      default: rd_data = 8'h00;
    endcase
  end

  // Register file, commit capture and the cursor's auto-advance wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_hist    <= 1'b0;
      col         <= 8'h00;
      row         <= 8'h00;
      chr         <= 8'h20;
      fg          <= 8'h0F;
      bg          <= 8'h00;
      ctrl        <= 8'h01;
      commit_q    <= 1'b0;
      commit_addr <= '0;
      cell_data_q <= '0;
      o_data      <= 8'h00;
    end else begin
      cmd_hist <= i_cmd_clk;
      o_data   <= rd_data;
      commit_q <= wr_commit;
      if (wr_commit) begin
        commit_addr <= cursor_addr;
        cell_data_q <= {chr, fg, bg};
      end
      if (wr_fill) begin
        cell_data_q <= {chr, fg, bg};
      end
      if (fill_done) begin
        col <= 8'h00;
        row <= 8'h00;
      end else if (wr_ok) begin
        case (i_addr)
          7'h40: col <= (i_data > COL_MAX) ? COL_MAX : i_data;
          7'h41: row <= (i_data > ROW_MAX) ? ROW_MAX : i_data;
          7'h46: chr  <= i_data;
          7'h48: fg   <= i_data;
          7'h49: bg   <= i_data;
          7'h4C: ctrl <= i_data;
          7'h4A: begin
            if (ctrl[0]) begin
              if (col == COL_MAX) begin
                col <= 8'h00;
                row <= (row == ROW_MAX) ? 8'h00 : row + 8'd1;
              end else begin
                col <= col + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_cmd_responder.sv
// Self-checking bench: a command-level model predicts every cell write and busy cycle,
// plus literal expectations for readback, clamping, wrap, fill and reset-mid-fill.
module tb_text_cmd_responder;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        i_cmd_clk, i_we;
  logic [6:0]  i_addr;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_busy, o_cell_we;
  logic [12:0] o_cell_addr;
  logic [23:0] o_cell_data;

  text_cmd_responder #(.COLS(80), .ROWS(60), .AW(13)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .i_cmd_clk(i_cmd_clk), .i_we(i_we),
    .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .o_busy(o_busy),
    .o_cell_we(o_cell_we), .o_cell_addr(o_cell_addr), .o_cell_data(o_cell_data)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [12:0] addr;
    logic [23:0] data;
  } cellw_t;

  cellw_t     expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         weCount = 0;
  int         busyCount = 0;
  int         failPrints = 0;
  logic [12:0] lastAddr;
  logic [23:0] lastData;

  // Model of the programmer-visible state.
  int         mCol, mRow, mChar, mFg, mBg, mCtrl;
  int         fillStart, fillEnd;
  bit         fillPending;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (failPrints < 40) begin
        failPrints++;
        $display("[TB] FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
      end
    end
  endtask

  function automatic void modelReset();
    mCol = 0; mRow = 0; mChar = 'h20; mFg = 'h0F; mBg = 'h00; mCtrl = 'h01;
    fillStart = -100000; fillEnd = -100000; fillPending = 0;
    expQ.delete();
  endfunction

  function automatic void syncModel(input int k);
    if (fillPending && k > fillEnd) begin
      mCol = 0; mRow = 0; fillPending = 0;
    end
  endfunction

  function automatic bit busyAt(input int k);
    return (k >= fillStart) && (k <= fillEnd);
  endfunction

  // Effect of a write seen by the edge that follows cycle k.
  function automatic void modelWrite(input int a, input int d, input bit we, input int k);
    cellw_t w;
    syncModel(k);
    if (!we || busyAt(k)) return;
    case (a)
      'h40: mCol = (d > 79) ? 79 : d;
      'h41: mRow = (d > 59) ? 59 : d;
      'h46: mChar = d;
      'h48: mFg = d;
      'h49: mBg = d;
      'h4C: mCtrl = d;
      'h4A: begin
        w.cyc = k + 1;
        w.addr = 13'(mRow * 80 + mCol);
        w.data = {8'(mChar), 8'(mFg), 8'(mBg)};
        expQ.push_back(w);
        if (mCtrl % 2 == 1) begin
          mCol++;
          if (mCol == 80) begin
            mCol = 0;
            mRow = (mRow + 1) % 60;
          end
        end
      end
      'h4B: begin
        fillStart = k + 1;
        fillEnd = k + 4800;
        fillPending = 1;
        for (int i = 0; i < 4800; i++) begin
          w.cyc = k + 1 + i;
          w.addr = 13'(i);
          w.data = {8'(mChar), 8'(mFg), 8'(mBg)};
          expQ.push_back(w);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int modelRead(input int a, input int k);
    syncModel(k);
    case (a)
      'h40: return mCol;
      'h41: return mRow;
      'h46: return mChar;
      'h48: return mFg;
      'h49: return mBg;
      'h4A, 'h4B: return busyAt(k) ? 1 : 0;
      'h4C: return mCtrl;
      default: return 0;
    endcase
  endfunction

  // Per-cycle comparison of the cell write port and busy flag against the model.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (o_cell_we) begin
        weCount++;
        lastAddr = o_cell_addr;
        lastData = o_cell_data;
      end
      if (o_busy) busyCount++;
      checkOutput("busy", 32'(o_busy), 32'(busyAt(cyc)));
      if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        checkOutput("cell_we", 32'(o_cell_we), 32'd1);
        checkOutput("cell_addr", 32'(o_cell_addr), 32'(expQ[0].addr));
        checkOutput("cell_data", 32'(o_cell_data), 32'(expQ[0].data));
        void'(expQ.pop_front());
      end else begin
        checkOutput("cell_we_idle", 32'(o_cell_we), 32'd0);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d, input logic we, input int hold);
    i_cmd_clk = 1'b1; i_we = we; i_addr = a; i_data = d;
    modelWrite(int'(a), int'(d), we, cyc);
    repeat (hold) stepCycle();
    i_cmd_clk = 1'b0; i_we = 1'b0;
    stepCycle();
  endtask

  task automatic readModel(input string name, input logic [6:0] a);
    int k;
    k = cyc;
    i_addr = a;
    stepCycle();
    checkOutput(name, 32'(o_data), 32'(modelRead(int'(a), k)));
  endtask

  task automatic readLit(input string name, input logic [6:0] a, input logic [7:0] exp);
    i_addr = a;
    stepCycle();
    checkOutput(name, 32'(o_data), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    modelReset();
    rstn_i = 1'b0; i_cmd_clk = 1'b0; i_we = 1'b0; i_addr = 7'h00; i_data = 8'h00;
    #1;
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_we", 32'(o_cell_we), 32'd0);
    checkOutput("rst_addr", 32'(o_cell_addr), 32'd0);
    checkOutput("rst_cdata", 32'(o_cell_data), 32'd0);
    stepCycle(); stepCycle();
    rstn_i = 1'b1;
    stepCycle();

    readLit("rst_char", 7'h46, 8'h20);
    readLit("rst_fg", 7'h48, 8'h0F);
    readLit("rst_ctrl", 7'h4C, 8'h01);
    readModel("rst_col", 7'h40);

    // Single commit with auto-advance.
    applyStimulus(7'h46, 8'h62, 1'b1, 1);
    applyStimulus(7'h48, 8'h03, 1'b1, 1);
    applyStimulus(7'h49, 8'h07, 1'b1, 1);
    applyStimulus(7'h40, 8'd5, 1'b1, 1);
    applyStimulus(7'h41, 8'd2, 1'b1, 1);
    base = weCount;
    applyStimulus(7'h4A, 8'hAA, 1'b1, 1);
    checkOutput("commit_count", 32'(weCount - base), 32'd1);
    checkOutput("commit_addr", 32'(lastAddr), 32'd165);
    checkOutput("commit_data", 32'(lastData), 32'h620307);
    readLit("adv_col", 7'h40, 8'd6);
    readModel("adv_row", 7'h41);

    // Wrap at the last cell, then the same with auto-advance off.
    applyStimulus(7'h40, 8'd79, 1'b1, 1);
    applyStimulus(7'h41, 8'd59, 1'b1, 1);
    applyStimulus(7'h4A, 8'h00, 1'b1, 1);
    checkOutput("wrap_addr", 32'(lastAddr), 32'd4799);
    readLit("wrap_col", 7'h40, 8'd0);
    readLit("wrap_row", 7'h41, 8'd0);
    applyStimulus(7'h4C, 8'h00, 1'b1, 1);
    applyStimulus(7'h40, 8'd79, 1'b1, 1);
    applyStimulus(7'h41, 8'd59, 1'b1, 1);
    applyStimulus(7'h4A, 8'h00, 1'b1, 1);
    readLit("noadv_col", 7'h40, 8'd79);
    readLit("noadv_row", 7'h41, 8'd59);

    // Clamping and unmapped addresses.
    applyStimulus(7'h40, 8'd200, 1'b1, 1);
    readLit("clamp_col", 7'h40, 8'h4F);
    applyStimulus(7'h41, 8'd99, 1'b1, 1);
    readLit("clamp_row", 7'h41, 8'h3B);
    applyStimulus(7'h47, 8'h5A, 1'b1, 1);
    readLit("unmapped", 7'h47, 8'h00);
    applyStimulus(7'h4C, 8'hA5, 1'b1, 1);
    readModel("ctrl_rb", 7'h4C);

    // Held strobe gives one pulse; a read strobe gives none.
    base = weCount;
    applyStimulus(7'h4A, 8'h00, 1'b1, 10);
    checkOutput("held_count", 32'(weCount - base), 32'd1);
    readModel("held_col", 7'h40);
    base = weCount;
    applyStimulus(7'h4A, 8'h00, 1'b0, 1);
    stepCycle();
    checkOutput("read_strobe_count", 32'(weCount - base), 32'd0);

    // Full-screen fill with a dropped write in the middle.
    applyStimulus(7'h46, 8'h41, 1'b1, 1);
    applyStimulus(7'h48, 8'h0F, 1'b1, 1);
    applyStimulus(7'h49, 8'h00, 1'b1, 1);
    busyCount = 0;
    applyStimulus(7'h4B, 8'h00, 1'b1, 1);
    repeat (50) stepCycle();
    applyStimulus(7'h46, 8'h55, 1'b1, 1);
    readLit("fill_char_kept", 7'h46, 8'h41);
    readLit("fill_busy_rb", 7'h4A, 8'h01);
    readModel("fill_busy_model", 7'h4B);
    for (int n = 0; n < 6000 && cyc <= fillEnd + 2; n++) stepCycle();
    checkOutput("fill_busy_cycles", 32'(busyCount), 32'd4800);
    checkOutput("fill_last_addr", 32'(lastAddr), 32'd4799);
    checkOutput("fill_last_data", 32'(lastData), 32'h410F00);
    readLit("fill_end_col", 7'h40, 8'd0);
    readLit("fill_end_row", 7'h41, 8'd0);
    readLit("fill_done_rb", 7'h4A, 8'h00);

    // Reset in the middle of a fill.
    applyStimulus(7'h4B, 8'h00, 1'b1, 1);
    for (int n = 0; n < 200 && cyc < fillStart + 100; n++) stepCycle();
    base = weCount;
    rstn_i = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_we", 32'(o_cell_we), 32'd0);
    stepCycle(); stepCycle();
    rstn_i = 1'b1;
    stepCycle();
    readLit("midrst_char", 7'h46, 8'h20);
    readLit("midrst_fg", 7'h48, 8'h0F);
    readLit("midrst_bg", 7'h49, 8'h00);
    readLit("midrst_ctrl", 7'h4C, 8'h01);
    readLit("midrst_col", 7'h40, 8'h00);
    readModel("midrst_row", 7'h41);
    repeat (20) stepCycle();
    checkOutput("midrst_no_writes", 32'(weCount - base), 32'd0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_cmd_responder.md
Name: text_cmd_responder

Overview:
- Responder for the strobed byte-wide text command bus driven by the top-level sequencer or CPU: command clock strobe, write enable, 7-bit address, 8-bit data.
- Holds cursor and staged-cell registers, and commits single cells or whole-screen fills into the text cell memory write port.
- Returns register readback.
- Sits between the command initiator and the text cell RAM, in the pix_clk domain.

Parameters:
- COLS, 80, text columns (640/8).
- ROWS, 60, text rows (480/8).
- AW, 13, cell memory address width; must satisfy 2^AW >= COLS*ROWS.

Ports:
- clk_i  in  1  block clock; the command bus is synchronous to it.
- rstn_i  in  1  reset, asynchronous, active-low.
- i_cmd_clk  in  1  command strobe; an access occurs on its sampled 0->1 transition.
- i_we  in  1  1 = write, 0 = read; qualified by the strobe edge.
- i_addr  in  7  register address.
- i_data  in  8  write data.
- o_data  out  8  readback of the register at i_addr.
- o_busy  out  1  fill in progress.
- o_cell_we  out  1  cell memory write enable.
- o_cell_addr  out  AW  cell index, row*COLS+col.
- o_cell_data  out  24  {char[23:16], fg[15:8], bg[7:0]}.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rstn_i.
- Reset values: col=0, row=0, char=0x20, fg=0x0F, bg=0x00, ctrl=0x01, state=IDLE, strobe history=0, o_data=0, o_busy=0, o_cell_we=0, o_cell_addr=0, o_cell_data=0.
- Strobe detection: i_cmd_clk is registered each clock into a history bit. An edge is i_cmd_clk==1 with history==0. A strobe held high for many cycles counts as one edge.
- Register map (write effect / read value):
  - 0x40 col: written value clamped to COLS-1 / reads col.
  - 0x41 row: written value clamped to ROWS-1 / reads row.
  - 0x46 char: stores byte / reads byte.
  - 0x48 fg: stores byte / reads byte.
  - 0x49 bg: stores byte / reads byte.
  - 0x4A commit: data ignored; writes the staged cell at the cursor / reads {7'b0, o_busy}.
  - 0x4B fill: data ignored; starts a screen fill / reads {7'b0, o_busy}.
  - 0x4C ctrl: bit0 = auto-advance, upper bits stored / reads ctrl.
  - Other addresses: writes ignored, reads 0x00.
- Readback: o_data is registered from i_addr every clock, independent of the strobe. Latency is 1 cycle. A read strobe has no side effect.
- Timing reference: a write edge sampled at clock edge N updates its target register at edge N.
- Commit timing: o_cell_we=1 for exactly the cycle after edge N. o_cell_addr = row*COLS+col and o_cell_data = staged fields, both captured at edge N, using pre-advance cursor values.
- Address arithmetic: for COLS=80, row*80 = (row<<6)+(row<<4), computed at AW bits with no overflow for legal row and col.
- Auto-advance (ctrl[0]=1, applied at edge N of a commit):
  - col+1.
  - If col==COLS-1: col=0 and row+1.
  - If also row==ROWS-1: row=0.
- States:
  - IDLE: 0x4B write -> FILL. o_busy=1 and the fill counter=0 from the next cycle.
  - FILL: o_cell_we=1 every cycle, o_cell_addr=counter, o_cell_data=staged cell latched at fill start. Counter increments each cycle.
  - FILL end: after the cycle with counter==COLS*ROWS-1 -> IDLE, o_busy=0, o_cell_we=0, col=row=0.
- While busy: all write strobes are dropped, not queued. Reads still work. The strobe history keeps updating, so a strobe held across the end of the fill does not fire.
- Simultaneous: a commit whose data cycle coincides with fill start cannot happen, because both need edges and only one edge exists per strobe.
- Reset mid-fill: immediate return to reset values; o_cell_we drops asynchronously.

Test Plan:
- Write 0x46=0x62, 0x48=0x03, 0x49=0x07, then 0x4A with col=5, row=2 -> one cycle of o_cell_we, o_cell_addr=165, o_cell_data=0x620307; col becomes 6.
- col=79, row=59, ctrl=1, commit -> o_cell_addr=4799; col=0, row=0 afterwards. Repeat with ctrl=0 -> cursor unchanged.
- Write col=200, row=99 -> readback of 0x40=79 (0x4F) and of 0x41=59 (0x3B), one cycle after i_addr is set.
- Fill with staged 0x410F00 -> o_busy high for exactly 4800 cycles, addresses 0..4799 consecutive, data constant. Write 0x46 mid-fill is ignored (reads the old value). Cursor is 0,0 at the end.
- i_cmd_clk held high for 10 cycles on a commit -> exactly one o_cell_we pulse. Read-only strobe at 0x4A -> no pulse.
- Deassert rstn_i at fill cycle 100 -> o_busy=0 and o_cell_we=0 immediately, all registers at reset values, no further writes.
